// File: rtl/count_seq_checker.sv
// Receive-side checker for the counting FSM code stream: validates transitions,
// recovers input 'a', tracks lock. Optional error counter: SEQCHK_ERRCNT_EN.
module count_seq_checker #(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [2:0]       code,
    output logic             a_rec,
    output logic             a_rec_valid,
    output logic             locked,
    output logic             err,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(UNLOCK_N + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_N - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_N - 1);

    state_t          state_q, state_d;
    logic [2:0]      prev_code_q, prev_code_d;
    logic            prev_ok_q, prev_ok_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
    logic            a_rec_q, a_rec_d;
    logic            a_rec_valid_q, a_rec_valid_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic            lock_lost_q, lock_lost_d;

    logic code_legal, hit, branch, a_bit;
    logic is_resync, is_good, is_bad;

    // Transition table lookup; branch marks the transitions that reveal 'a'.
    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        hit    = 1'b0;
        branch = 1'b0;
        a_bit  = 1'b0;
        case ({prev_code_q, code})
            {3'd2, 3'd4}: hit = 1'b1;
            {3'd4, 3'd6}: begin hit = 1'b1; branch = 1'b1; a_bit = 1'b0; end
            {3'd4, 3'd7}: begin hit = 1'b1; branch = 1'b1; a_bit = 1'b1; end
            {3'd6, 3'd5}: hit = 1'b1;
            {3'd5, 3'd2}: begin hit = 1'b1; branch = 1'b1; a_bit = 1'b0; end
            {3'd5, 3'd4}: begin hit = 1'b1; branch = 1'b1; a_bit = 1'b1; end
            {3'd7, 3'd6}: hit = 1'b1;
            default: ;
        endcase
    end

    assign code_legal = (code == 3'd2) || (code >= 3'd4);
    assign is_resync  = !prev_ok_q && code_legal;
    assign is_good    = prev_ok_q && hit;
    assign is_bad     = !is_resync && !is_good;

    // State register and per-sample bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            prev_code_q <= 3'd0;
            prev_ok_q   <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_code_q <= prev_code_d;
            prev_ok_q   <= prev_ok_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        prev_code_d = prev_code_q;
        prev_ok_d   = prev_ok_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        if (code_valid) begin
            prev_code_d = code;
            prev_ok_d   = code_legal;
            case (state_q)
                HUNT: begin
                    if (code_legal) begin
                        state_d    = CHECK;
                        good_cnt_d = '0;
                    end
                end
                CHECK: begin
                    if (is_good) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d   = LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else if (is_bad) begin
                        if (code_legal) good_cnt_d = '0;
                        else            state_d    = HUNT;
                    end
                end
                LOCKED: begin
                    if (is_good) begin
                        bad_cnt_d = '0;
                    end else if (is_bad) begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                        if (bad_cnt_q == BAD_LAST) state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output logic; every output is registered one clock after the sample.
    always_comb begin
        a_rec_d       = a_rec_q;
        a_rec_valid_d = 1'b0;
        err_d         = 1'b0;
        lock_lost_d   = 1'b0;
        locked_d      = (state_d == LOCKED);
        if (code_valid) begin
            if (state_q != HUNT && is_good && branch) begin
                a_rec_valid_d = 1'b1;
                a_rec_d       = a_bit;
            end
            if (state_q == LOCKED && is_bad) begin
                err_d       = 1'b1;
                lock_lost_d = (state_d == HUNT);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_rec_q       <= 1'b0;
            a_rec_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            a_rec_q       <= a_rec_d;
            a_rec_valid_q <= a_rec_valid_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign a_rec       = a_rec_q;
    assign a_rec_valid = a_rec_valid_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign lock_lost   = lock_lost_q;

`ifdef SEQCHK_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts in step with the err pulse so both appear on the same cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: expected outputs are queued when a
// sample is driven and compared one clock later.
module tb_count_seq_checker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             code_valid;
    logic [2:0]       code;
    logic             a_rec, a_rec_valid, locked, err, lock_lost;
    logic [CNT_W-1:0] err_cnt;

    typedef struct packed {
        logic             a_rec;
        logic             a_rec_valid;
        logic             locked;
        logic             err;
        logic             lock_lost;
        logic [CNT_W-1:0] err_cnt;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    count_seq_checker #(.LOCK_N(3), .UNLOCK_N(2), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .a_rec      (a_rec),
        .a_rec_valid(a_rec_valid),
        .locked     (locked),
        .err        (err),
        .lock_lost  (lock_lost),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // e = {a_rec, a_rec_valid, locked, err, lock_lost}
    task automatic push_exp(input logic [4:0] e);
        exp_t x;
`ifdef SEQCHK_ERRCNT_EN
        if (e[1] && model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1'b1;
`endif
        x = {e, model_cnt};
        sb_q.push_back(x);
    endtask

    task automatic compare(input string tag);
        exp_t x;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
            return;
        end
        x = sb_q.pop_front();
        check({tag, "_a_rec"},       CNT_W'(a_rec),       CNT_W'(x.a_rec));
        check({tag, "_a_rec_valid"}, CNT_W'(a_rec_valid), CNT_W'(x.a_rec_valid));
        check({tag, "_locked"},      CNT_W'(locked),      CNT_W'(x.locked));
        check({tag, "_err"},         CNT_W'(err),         CNT_W'(x.err));
        check({tag, "_lock_lost"},   CNT_W'(lock_lost),   CNT_W'(x.lock_lost));
        check({tag, "_err_cnt"},     err_cnt,             x.err_cnt);
    endtask

    task automatic step(input string tag, input logic v, input logic [2:0] c, input logic [4:0] e);
        code_valid = v;
        code       = c;
        push_exp(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        reset      = 1'b0;
        code_valid = 1'b0;
        code       = 3'd0;

        // Reset values, before and after clock edges with reset held.
        #3;
        push_exp(5'b00000); compare("rst_pre_clk");
        @(posedge clk); #1;
        push_exp(5'b00000); compare("rst_held");
        reset = 1'b1;
        step("idle_after_rst", 1'b0, 3'd0, 5'b00000);

        // Acquire lock on 2,4,6,5 and recover a=0.
        step("s2",  1'b1, 3'd2, 5'b00000);
        step("s4",  1'b1, 3'd4, 5'b00000);
        step("s6",  1'b1, 3'd6, 5'b01000);
        step("s5",  1'b1, 3'd5, 5'b00100);
        step("s2b", 1'b1, 3'd2, 5'b01100);
        step("s4b", 1'b1, 3'd4, 5'b00100);

        // a=1 branches while locked.
        step("b6",  1'b1, 3'd6, 5'b01100);
        step("b5",  1'b1, 3'd5, 5'b00100);
        step("b4",  1'b1, 3'd4, 5'b11100);
        step("b7",  1'b1, 3'd7, 5'b11100);
        step("b6b", 1'b1, 3'd6, 5'b10100);
        step("b5b", 1'b1, 3'd5, 5'b10100);
        step("b4b", 1'b1, 3'd4, 5'b11100);
        step("b7b", 1'b1, 3'd7, 5'b11100);

        // Single bad transitions followed by good ones keep lock.
        step("l6",    1'b1, 3'd6, 5'b10100);
        step("l6to4", 1'b1, 3'd4, 5'b10110);
        step("l4to6", 1'b1, 3'd6, 5'b01100);
        step("l5",    1'b1, 3'd5, 5'b00100);
        step("l5to5", 1'b1, 3'd5, 5'b00110);
        step("l5to4", 1'b1, 3'd4, 5'b11100);

        // Two consecutive bad samples drop lock.
        step("u3", 1'b1, 3'd3, 5'b10110);
        step("u0", 1'b1, 3'd0, 5'b10011);

        // Illegal codes keep the checker hunting.
        step("h0", 1'b1, 3'd0, 5'b10000);
        step("h3", 1'b1, 3'd3, 5'b10000);

        // Reacquire with code_valid gaps interleaved.
        step("g2",    1'b1, 3'd2, 5'b10000);
        step("gap1",  1'b0, 3'd5, 5'b10000);
        step("g4",    1'b1, 3'd4, 5'b10000);
        step("gap2",  1'b0, 3'd3, 5'b10000);
        step("g6",    1'b1, 3'd6, 5'b01000);
        step("gap3",  1'b0, 3'd7, 5'b00000);
        step("g5",    1'b1, 3'd5, 5'b00100);
        step("gap4",  1'b0, 3'd0, 5'b00100);
        step("gap5",  1'b0, 3'd3, 5'b00100);

        // Asynchronous reset mid-LOCKED, between clock edges.
        #2;
        reset = 1'b0;
        #1;
        model_cnt = '0;
        push_exp(5'b00000); compare("async_rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // A bad legal sample in CHECK restarts the good count.
        step("c2",    1'b1, 3'd2, 5'b00000);
        step("c4",    1'b1, 3'd4, 5'b00000);
        step("c4to2", 1'b1, 3'd2, 5'b00000);
        step("c4b",   1'b1, 3'd4, 5'b00000);
        step("c6",    1'b1, 3'd6, 5'b01000);
        step("c5",    1'b1, 3'd5, 5'b00100);
        step("c3",    1'b1, 3'd3, 5'b00110);
        step("cidle", 1'b0, 3'd0, 5'b00100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
